// File: rtl/i2c_write_sequencer.sv
// Transaction sequencer for the I2C master byte engine: START, address, register, payload, STOP.
// Define I2C_SEQ_RETRY_EN to retry address NACKs up to MAX_RETRIES times before reporting status 1.
module i2c_write_sequencer #(
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_dev_addr,
  input  logic [7:0]       req_reg_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       data_in,
  output logic             data_req,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic             eng_cmd_valid,
  output logic [1:0]       eng_cmd,
  output logic [7:0]       eng_byte,
  input  logic             eng_done,
  input  logic             eng_nack,
  input  logic             eng_timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_REG    = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_ADDR_NACK = 2'd1;
  localparam logic [1:0] ST_DATA_NACK = 2'd2;
  localparam logic [1:0] ST_TIMEOUT   = 2'd3;

  logic [2:0]       state;
  logic [6:0]       devAddr;
  logic [7:0]       regAddr;
  logic [LEN_W-1:0] remaining;
  logic [7:0]       byteReg;
  logic             cmdValid;
  logic [1:0]       cmdReg;
  logic             dataReq;
  logic [1:0]       statusReg;
  logic [1:0]       pendStatus;

`ifdef I2C_SEQ_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRIES < 4) ? 2 : $clog2(MAX_RETRIES + 1);
  logic [RETRY_W-1:0] retryCnt;
  logic               restartPending;
`endif

  assign req_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE) || req_valid;
  assign done          = (state == S_FINISH);
  assign status        = statusReg;
  assign eng_cmd_valid = cmdValid;
  assign eng_cmd       = cmdReg;
  assign data_req      = dataReq;
  // Payload byte is passed straight through in its request cycle, then held from byteReg.
  assign eng_byte      = dataReq ? data_in : byteReg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      devAddr    <= '0;
      regAddr    <= '0;
      remaining  <= '0;
      byteReg    <= '0;
      cmdValid   <= 1'b0;
      cmdReg     <= CMD_START;
      dataReq    <= 1'b0;
      statusReg  <= ST_OK;
      pendStatus <= ST_OK;
`ifdef I2C_SEQ_RETRY_EN
      retryCnt       <= '0;
      restartPending <= 1'b0;
`endif
    end else begin
      dataReq <= 1'b0;
      if (dataReq) byteReg <= data_in;

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            devAddr    <= req_dev_addr;
            regAddr    <= req_reg_addr;
            remaining  <= req_len;
            statusReg  <= ST_OK;
            pendStatus <= ST_OK;
            cmdValid   <= 1'b1;
            cmdReg     <= CMD_START;
            state      <= S_START;
`ifdef I2C_SEQ_RETRY_EN
            retryCnt       <= '0;
            restartPending <= 1'b0;
`endif
          end
        end

        S_FINISH: state <= S_IDLE;

        default: begin
          if (!cmdValid) begin
            // Gap cycle after each completed command: launch the command for the current state.
            cmdValid <= 1'b1;
            case (state)
              S_START: cmdReg <= CMD_START;
              S_ADDR: begin
                cmdReg  <= CMD_WRITE;
                byteReg <= {devAddr, 1'b0};
              end
              S_REG: begin
                cmdReg  <= CMD_WRITE;
                byteReg <= regAddr;
              end
              S_DATA: begin
                cmdReg  <= CMD_WRITE;
                dataReq <= 1'b1;
              end
              default: cmdReg <= CMD_STOP;
            endcase
          end else if (eng_done) begin
            cmdValid <= 1'b0;
            if (eng_timeout) begin
              statusReg <= ST_TIMEOUT;
              state     <= S_FINISH;
            end else begin
              case (state)
                S_START: state <= S_ADDR;
                S_ADDR: begin
                  if (eng_nack) begin
`ifdef I2C_SEQ_RETRY_EN
                    if (retryCnt < RETRY_W'(MAX_RETRIES)) begin
                      retryCnt       <= retryCnt + RETRY_W'(1);
                      restartPending <= 1'b1;
                    end else begin
                      pendStatus <= ST_ADDR_NACK;
                    end
`else
                    pendStatus <= ST_ADDR_NACK;
`endif
                    state <= S_STOP;
                  end else begin
                    state <= S_REG;
                  end
                end
                S_REG: begin
                  if (eng_nack) begin
                    pendStatus <= ST_DATA_NACK;
                    state      <= S_STOP;
                  end else if (remaining != '0) begin
                    state <= S_DATA;
                  end else begin
                    state <= S_STOP;
                  end
                end
                S_DATA: begin
                  remaining <= remaining - LEN_W'(1);
                  if (eng_nack) begin
                    pendStatus <= ST_DATA_NACK;
                    state      <= S_STOP;
                  end else if (remaining != LEN_W'(1)) begin
                    state <= S_DATA;
                  end else begin
                    state <= S_STOP;
                  end
                end
                default: begin
`ifdef I2C_SEQ_RETRY_EN
                  if (restartPending) begin
                    restartPending <= 1'b0;
                    state          <= S_START;
                  end else
`endif
                  begin
                    statusReg <= pendStatus;
                    state     <= S_FINISH;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Scoreboard bench for i2c_write_sequencer: expected engine commands are queued from a
// small reference model and popped as the DUT issues them; an engine model answers each.
module tb_i2c_write_sequencer;

  localparam int unsigned LEN_W       = 4;
  localparam int unsigned MAX_RETRIES = 3;
  localparam logic [1:0]  CMD_START   = 2'd0;
  localparam logic [1:0]  CMD_WRITE   = 2'd1;
  localparam logic [1:0]  CMD_STOP    = 2'd2;

  logic             clk;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_dev_addr;
  logic [7:0]       req_reg_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       data_in;
  logic             data_req;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic             eng_cmd_valid;
  logic [1:0]       eng_cmd;
  logic [7:0]       eng_byte;
  logic             eng_done;
  logic             eng_nack;
  logic             eng_timeout;

  i2c_write_sequencer #(.LEN_W(LEN_W), .MAX_RETRIES(MAX_RETRIES)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_len(req_len),
    .data_in(data_in), .data_req(data_req),
    .busy(busy), .done(done), .status(status),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd(eng_cmd), .eng_byte(eng_byte),
    .eng_done(eng_done), .eng_nack(eng_nack), .eng_timeout(eng_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] b;
    bit         nack;
    bit         tmo;
    bit         isData;
  } cmd_t;

  cmd_t expQ[$];
  int   nChecks = 0;
  int   nFail   = 0;

  // Scenario configuration
  logic [6:0] cDev;
  logic [7:0] cReg;
  int         cLen;
  logic [7:0] pay [16];
  int         cAddrNacks;
  bit         cRegNack;
  int         cDataNackIdx;
  int         cTmoIdx;
  bit         cSpurious;
  bit         cResetOnData;
  logic [1:0] expStatus;
  int         expDataReq;

  function automatic void pushCmd(logic [1:0] c, logic [7:0] b, bit n, bit d);
    cmd_t e;
    e.cmd = c; e.b = b; e.nack = n; e.tmo = 1'b0; e.isData = d;
    expQ.push_back(e);
  endfunction

  function automatic void setDefaults();
    cDev = 7'h68; cReg = 8'h0E; cLen = 0;
    for (int i = 0; i < 16; i++) pay[i] = 8'h00;
    cAddrNacks = 0; cRegNack = 0; cDataNackIdx = -1; cTmoIdx = -1;
    cSpurious = 0; cResetOnData = 0;
  endfunction

  function automatic void buildModel();
    int   maxAttempts;
    cmd_t tmp;
    expQ.delete();
    expStatus = 2'd0;
`ifdef I2C_SEQ_RETRY_EN
    maxAttempts = MAX_RETRIES + 1;
`else
    maxAttempts = 1;
`endif
    for (int a = 0; a < maxAttempts; a++) begin
      pushCmd(CMD_START, 8'h00, 0, 0);
      pushCmd(CMD_WRITE, {cDev, 1'b0}, a < cAddrNacks, 0);
      if (a < cAddrNacks) begin
        pushCmd(CMD_STOP, 8'h00, 0, 0);
        if (a == maxAttempts - 1) expStatus = 2'd1;
        continue;
      end
      pushCmd(CMD_WRITE, cReg, cRegNack, 0);
      if (cRegNack) expStatus = 2'd2;
      else begin
        for (int i = 0; i < cLen; i++) begin
          pushCmd(CMD_WRITE, pay[i], i == cDataNackIdx, 1);
          if (i == cDataNackIdx) begin
            expStatus = 2'd2;
            break;
          end
        end
      end
      pushCmd(CMD_STOP, 8'h00, 0, 0);
      break;
    end
    if (cTmoIdx >= 0 && cTmoIdx < expQ.size()) begin
      tmp = expQ[cTmoIdx];
      tmp.tmo = 1'b1;
      expQ[cTmoIdx] = tmp;
      while (expQ.size() > cTmoIdx + 1) void'(expQ.pop_back());
      expStatus = 2'd3;
    end
    expDataReq = 0;
    foreach (expQ[i]) if (expQ[i].isData) expDataReq++;
  endfunction

  task automatic checkResetOutputs(input string name);
    nChecks++;
    if ({req_ready, eng_cmd_valid, data_req, done, busy, status, eng_cmd, eng_byte} !== {1'b1, 16'h0}) begin
      nFail++;
      $display("FAIL %s: rdy=%b cv=%b dreq=%b done=%b busy=%b st=%0d cmd=%0d byte=%02h, required rdy=1 rest 0",
               name, req_ready, eng_cmd_valid, data_req, done, busy, status, eng_cmd, eng_byte);
    end
  endtask

  // Drives one request, plays the byte engine and scores every command against the model.
  task automatic runTxn(input string name);
    int   cyc, pIdx, drCnt, phase;
    bit   firstCmd, finished, advance;
    cmd_t cur;
    buildModel();
    pIdx = 0; drCnt = 0; phase = 0; firstCmd = 1; finished = 0; advance = 0;
    cur.cmd = 2'd0; cur.b = 8'd0; cur.nack = 0; cur.tmo = 0; cur.isData = 0;
    data_in      = pay[0];
    req_valid    = 1'b1;
    req_dev_addr = cDev;
    req_reg_addr = cReg;
    req_len      = LEN_W'(cLen);
    @(negedge clk);
    nChecks++;
    if (req_ready !== 1'b1 || busy !== 1'b1) begin
      nFail++;
      $display("FAIL %s accept: rdy=%b busy=%b, required 1 1", name, req_ready, busy);
    end
    @(posedge clk); #1;
    // Keep valid high with different fields: must be ignored while busy.
    req_dev_addr = 7'($urandom);
    req_reg_addr = 8'($urandom);
    req_len      = LEN_W'($urandom);
    cyc = 0;
    while (!finished && cyc < 400) begin
      cyc++;
      @(negedge clk);
      if (phase == 2) begin
        eng_done = 1'b0; eng_nack = 1'b0; eng_timeout = 1'b0;
        nChecks++;
        if (eng_cmd_valid !== 1'b0) begin
          nFail++;
          $display("FAIL %s drop: cmd_valid=%b after eng_done, required 0", name, eng_cmd_valid);
        end
        phase = 0;
        if (cSpurious) begin
          eng_done = 1'b1; eng_nack = 1'b1;
        end
      end else if (phase == 0) begin
        eng_done = 1'b0; eng_nack = 1'b0;
        if (eng_cmd_valid === 1'b1) begin
          if (firstCmd) begin
            nChecks++;
            if (cyc != 1) begin
              nFail++;
              $display("FAIL %s latency: first command %0d cycles after accept, required 1", name, cyc);
            end
          end
          firstCmd = 0;
          nChecks++;
          if (expQ.size() == 0) begin
            nFail++;
            $display("FAIL %s extra cmd: got cmd=%0d byte=%02h, required none", name, eng_cmd, eng_byte);
            cur.cmd = eng_cmd; cur.b = eng_byte; cur.nack = 0; cur.tmo = 0;
          end else begin
            cur = expQ.pop_front();
            if (eng_cmd !== cur.cmd || (cur.cmd == CMD_WRITE && eng_byte !== cur.b)) begin
              nFail++;
              $display("FAIL %s cmd: got cmd=%0d byte=%02h, required cmd=%0d byte=%02h",
                       name, eng_cmd, eng_byte, cur.cmd, cur.b);
            end
          end
          phase = 1;
        end
      end else begin
        nChecks++;
        if (eng_cmd_valid !== 1'b1 || eng_cmd !== cur.cmd || (cur.cmd == CMD_WRITE && eng_byte !== cur.b)) begin
          nFail++;
          $display("FAIL %s hold: got v=%b cmd=%0d byte=%02h, required v=1 cmd=%0d byte=%02h",
                   name, eng_cmd_valid, eng_cmd, eng_byte, cur.cmd, cur.b);
        end
        eng_done = 1'b1; eng_nack = cur.nack; eng_timeout = cur.tmo;
        phase = 2;
      end

      if (data_req === 1'b1) begin
        drCnt++;
        advance = 1;
        nChecks++;
        if (eng_cmd_valid !== 1'b1 || eng_byte !== data_in) begin
          nFail++;
          $display("FAIL %s data_req: cmd_valid=%b byte=%02h, required 1 %02h", name, eng_cmd_valid, eng_byte, data_in);
        end
        if (cResetOnData) begin
          reset_n = 1'b0; req_valid = 1'b0;
          eng_done = 1'b0; eng_nack = 1'b0; eng_timeout = 1'b0;
          @(posedge clk); #1;
          reset_n = 1'b1;
          @(negedge clk);
          checkResetOutputs({name, " reset"});
          expQ.delete();
          @(posedge clk); #1;
          return;
        end
      end

      nChecks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        nFail++;
        $display("FAIL %s busy: rdy=%b busy=%b, required 0 1", name, req_ready, busy);
      end

      if (done === 1'b1) begin
        finished  = 1;
        req_valid = 1'b0;
        nChecks++;
        if (status !== expStatus) begin
          nFail++;
          $display("FAIL %s status: got %0d, required %0d", name, status, expStatus);
        end
        nChecks++;
        if (drCnt != expDataReq) begin
          nFail++;
          $display("FAIL %s data_req count: got %0d, required %0d", name, drCnt, expDataReq);
        end
        nChecks++;
        if (expQ.size() != 0) begin
          nFail++;
          $display("FAIL %s missing cmds: %0d outstanding, required 0", name, expQ.size());
        end
      end

      @(posedge clk); #1;
      if (advance) begin
        advance = 0;
        if (pIdx < 15) pIdx++;
        data_in = pay[pIdx];
      end
    end
    eng_done = 1'b0; eng_nack = 1'b0; eng_timeout = 1'b0; req_valid = 1'b0;
    if (!finished) begin
      nChecks++;
      nFail++;
      $display("FAIL %s timeout: no done within 400 cycles, required done", name);
    end else begin
      @(negedge clk);
      nChecks++;
      if (req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || eng_cmd_valid !== 1'b0 || status !== expStatus) begin
        nFail++;
        $display("FAIL %s post-done: rdy=%b done=%b busy=%b cv=%b st=%0d, required 1 0 0 0 %0d",
                 name, req_ready, done, busy, eng_cmd_valid, status, expStatus);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkResetOutputs("reset held");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset released");
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    setDefaults();
    cLen = 2; pay[0] = 8'hA5; pay[1] = 8'h3C;
    runTxn("basic");
  endtask

  task automatic test_len0();
    setDefaults();
    cDev = 7'h3C; cReg = 8'h81;
    runTxn("len0");
  endtask

  task automatic test_addr_nack();
    setDefaults();
    cLen = 2; pay[0] = 8'h11; pay[1] = 8'h22;
    cAddrNacks = 1;
    runTxn("addr nack once");
    setDefaults();
    cLen = 1; pay[0] = 8'h5A;
    cAddrNacks = MAX_RETRIES + 1;
    runTxn("addr nack always");
  endtask

  task automatic test_data_nack();
    setDefaults();
    cLen = 3; pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    cDataNackIdx = 1;
    runTxn("data nack");
    setDefaults();
    cLen = 2; pay[0] = 8'h77; pay[1] = 8'h88;
    cRegNack = 1;
    runTxn("reg nack");
  endtask

  task automatic test_timeout();
    setDefaults();
    cLen = 2; pay[0] = 8'hDE; pay[1] = 8'hAD;
    cTmoIdx = 2;
    runTxn("timeout reg");
    setDefaults();
    cLen = 3; pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
    cDataNackIdx = 1; cTmoIdx = 4;
    runTxn("timeout over nack");
  endtask

  task automatic test_max_len();
    setDefaults();
    cDev = 7'h51; cReg = 8'hF0;
    cLen = (1 << LEN_W) - 1;
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
    cSpurious = 1;
    runTxn("max len");
  endtask

  task automatic test_reset_mid();
    setDefaults();
    cLen = 3; pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hC3;
    cResetOnData = 1;
    runTxn("reset mid");
    setDefaults();
    cLen = 1; pay[0] = 8'h99;
    runTxn("after reset");
  endtask

  task automatic test_back_to_back();
    setDefaults();
    cDev = 7'h20; cReg = 8'h00; cLen = 1; pay[0] = 8'h42;
    runTxn("b2b first");
    setDefaults();
    cDev = 7'h7F; cReg = 8'hFF; cLen = 2; pay[0] = 8'hFF; pay[1] = 8'h00;
    runTxn("b2b second");
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0;
    req_dev_addr = '0; req_reg_addr = '0; req_len = '0; data_in = '0;
    eng_done = 1'b0; eng_nack = 1'b0; eng_timeout = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_addr_nack();
    test_data_nack();
    test_timeout();
    test_max_len();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/i2c_write_sequencer.md
Name: i2c_write_sequencer

Overview:
- Transaction-level controller for the I2C master byte engine used by the clock design (RTC/display register writes).
- Accepts one write request: 7-bit device address, 8-bit register pointer, N payload bytes.
- Drives the byte engine with a command stream START, address byte, register byte, N data bytes, STOP.
- Reports completion, NACK and clock-stretch-timeout status to the requester.

Parameters:
- LEN_W, 4, width of the payload length field; maximum payload is 2^LEN_W-1 bytes.
- MAX_RETRIES, 3, number of address-NACK retries; used only when I2C_SEQ_RETRY_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready.
- req_dev_addr  in  7  target device address.
- req_reg_addr  in  8  register pointer byte.
- req_len  in  LEN_W  number of payload bytes (0 is legal).
- data_in  in  8  next payload byte, sampled when data_req=1.
- data_req  out  1  one-cycle pulse; data_in is consumed this cycle.
- busy  out  1  high from the accept cycle until the done pulse, inclusive.
- done  out  1  one-cycle completion pulse.
- status  out  2  valid with done and held until the next accept: 0 OK, 1 address NACK, 2 data/register NACK, 3 timeout.
- eng_cmd_valid  out  1  command to the byte engine is valid.
- eng_cmd  out  2  0 START, 1 WRITE, 2 STOP (3 reserved, never driven).
- eng_byte  out  8  byte for a WRITE command.
- eng_done  in  1  one-cycle pulse from the engine: command finished.
- eng_nack  in  1  qualified by eng_done on a WRITE: slave did not ACK.
- eng_timeout  in  1  qualified by eng_done: clock-stretch timeout reached.

Behaviour:
- Reset values (cycle after reset_n=0 sampled):
  - req_ready=1; all other outputs 0.
  - State IDLE; counters cleared.
  - Reset mid-transaction aborts immediately with no STOP issued. The byte engine shares the same reset.
- Engine handshake:
  - eng_cmd_valid, eng_cmd and eng_byte stay stable from assertion until eng_done is sampled high.
  - eng_cmd_valid drops the cycle after eng_done.
  - Next command asserts one cycle later; at most one command is outstanding.
  - eng_done with eng_cmd_valid=0 is ignored.
- States:
  - IDLE: on accept, latch all req_* fields and the remaining-byte counter; go to START.
  - START: issue START (1 cycle after accept). On done → ADDR.
  - ADDR: WRITE with eng_byte={dev,1'b0}.
  - REG: WRITE with eng_byte=reg_addr.
  - DATA: assert data_req in the cycle the WRITE command asserts; eng_byte=data_in captured that cycle. Decrement the counter on each eng_done.
  - STOP: issue STOP. On done → FINISH.
  - FINISH: done=1 for one cycle → IDLE (req_ready=1 the following cycle).
- Transitions:
  - ADDR ok → REG.
  - REG ok → DATA if counter≠0, else STOP.
  - DATA ok → DATA while counter≠0 after decrement, else STOP.
  - Any eng_nack on ADDR → STOP with status 1; on REG or DATA → STOP with status 2. Remaining payload is not requested (no further data_req).
  - eng_timeout on any command → FINISH directly with status 3; no STOP, bus state unknown. Timeout takes precedence over a simultaneous nack.
- Boundaries:
  - req_len=0: sequence is START, ADDR, REG, STOP.
  - req_len=2^LEN_W-1: exactly that many data_req pulses.
  - req_valid during busy is ignored (req_ready=0).
  - Request fields may change after accept without effect.
- Counts: exactly one data_req per payload byte sent; the number of data_req pulses equals bytes written.

Optional Feature:
- Macro I2C_SEQ_RETRY_EN.
- Defined:
  - An address NACK issues STOP, then restarts from START with the same request, up to MAX_RETRIES times.
  - A 2-bit-wide-or-larger internal retry counter clears on accept.
  - Status 1 is reported only after the final retry NACKs.
  - A success on retry k reports status 0; payload bytes are requested only after a successful ADDR.
- Undefined:
  - An address NACK issues STOP, then FINISH with status 1.
  - MAX_RETRIES is unused.

Test Plan:
- dev=0x68, reg=0x0E, len=2, data 0xA5,0x3C, engine ACKs all → commands START, W 0xD0, W 0x0E, W 0xA5, W 0x3C, STOP; 2 data_req pulses; done with status 0; eng_cmd_valid first asserts 1 cycle after accept.
- len=0 → START, W addr, W reg, STOP; no data_req; status 0.
- Engine NACKs byte 0xD0 (retry disabled) → STOP next, no REG write, no data_req, status 1. With I2C_SEQ_RETRY_EN and MAX_RETRIES=3, NACK on every attempt → 4 START/ADDR/STOP cycles, then status 1. NACK only on the first attempt → completes normally with status 0.
- len=3, NACK on second data byte → exactly 2 data_req pulses, STOP, status 2.
- eng_timeout with eng_done during REG → no STOP command, done next state, status 3; req_ready=1 the cycle after done.
- reset_n=0 for 1 cycle during DATA → all outputs at reset values the next cycle, req_ready=1; a new request then runs cleanly from START.
